// File: rtl/teller_dispatch_scheduler.sv
// Bank-queue scheduler: issues tickets, tracks waiting customers and hands them
// round-robin to idle tellers whose service countdowns run off a shared tick.

module teller_lane #(
  parameter int SERVICE_TICKS = 5
) (
  input  logic FPGA_clk,
  input  logic reset,
  input  logic tick,
  input  logic load,
  output logic busy
);
  logic [7:0] count_q, count_d;
  logic       busy_q, busy_d;

  // load only ever hits an idle lane, so it never collides with a decrement
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (load) begin
      count_d = 8'(SERVICE_TICKS);
      busy_d  = 1'b1;
    end else if (tick && busy_q) begin
      count_d = count_q - 8'd1;
      busy_d  = (count_q != 8'd1);
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (reset) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
endmodule

module teller_dispatch_scheduler #(
  parameter int TICK_DIV      = 25_000_000,
  parameter int N_TELLERS     = 3,
  parameter int SERVICE_TICKS = 5,
  parameter int QMAX          = 15,
  parameter int TICKET_MOD    = 100
) (
  input  logic                       FPGA_clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       arrive,
  output logic [$clog2(QMAX+1)-1:0]  pending,
  output logic                       full,
  output logic [6:0]                 arrive_ticket,
  output logic [N_TELLERS-1:0]       teller_busy,
  output logic                       disp_valid,
  output logic [2:0]                 disp_teller,
  output logic [6:0]                 disp_ticket,
  output logic                       tick
);
  localparam int PW = $clog2(QMAX+1);
  localparam int CW = $clog2(TICK_DIV);

  typedef struct packed {
    logic       valid;
    logic [2:0] teller;
    logic [6:0] ticket;
  } disp_t;

  logic [CW-1:0]        pre_q, pre_d;
  logic                 tick_q, tick_d;
  logic [PW-1:0]        pending_q, pending_d;
  logic                 full_q, full_d;
  logic [6:0]           next_ticket_q, next_ticket_d;
  logic [6:0]           serve_ticket_q, serve_ticket_d;
  logic [6:0]           arrive_ticket_q, arrive_ticket_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  disp_t                disp_q, disp_d;
  logic [N_TELLERS-1:0] busy, load;
  logic [7:0]           idle_pad;
  logic [3:0]           cand;
  logic [2:0]           grant;
  logic                 grant_ok, accept, dispatch;

  function automatic logic [6:0] tkt_inc(input logic [6:0] t);
    return (t == 7'(TICKET_MOD-1)) ? 7'd0 : t + 7'd1;
  endfunction

  // Round-robin: first idle teller at or after rr_ptr, wrapping
  always_comb begin
    idle_pad                = '0;
    idle_pad[N_TELLERS-1:0] = ~busy;
    grant_ok                = 1'b0;
    grant                   = '0;
    cand                    = '0;
    for (int i = 0; i < N_TELLERS; i++) begin
      cand = {1'b0, rr_ptr_q} + 4'(i);
      if (cand >= 4'(N_TELLERS)) cand = cand - 4'(N_TELLERS);
      if (!grant_ok && idle_pad[cand[2:0]]) begin
        grant_ok = 1'b1;
        grant    = cand[2:0];
      end
    end
  end

  always_comb begin
    dispatch        = grant_ok && (pending_q != '0);
    accept          = arrive && (pending_q < PW'(QMAX));
    pending_d       = pending_q + PW'(accept) - PW'(dispatch);
    full_d          = (pending_d == PW'(QMAX));
    next_ticket_d   = accept ? tkt_inc(next_ticket_q) : next_ticket_q;
    arrive_ticket_d = accept ? next_ticket_q : arrive_ticket_q;
    serve_ticket_d  = dispatch ? tkt_inc(serve_ticket_q) : serve_ticket_q;
    rr_ptr_d        = rr_ptr_q;
    disp_d          = '{valid: 1'b0, teller: disp_q.teller, ticket: disp_q.ticket};
    if (dispatch) begin
      rr_ptr_d = (grant == 3'(N_TELLERS-1)) ? 3'd0 : grant + 3'd1;
      disp_d   = '{valid: 1'b1, teller: grant, ticket: serve_ticket_q};
    end
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (enable) begin
      tick_d = (pre_q == CW'(TICK_DIV-1));
      pre_d  = tick_d ? '0 : pre_q + CW'(1);
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (reset) begin
      pre_q           <= '0;
      tick_q          <= 1'b0;
      pending_q       <= '0;
      full_q          <= 1'b0;
      next_ticket_q   <= '0;
      serve_ticket_q  <= '0;
      arrive_ticket_q <= '0;
      rr_ptr_q        <= '0;
      disp_q          <= '0;
    end else begin
      pre_q           <= pre_d;
      tick_q          <= tick_d;
      pending_q       <= pending_d;
      full_q          <= full_d;
      next_ticket_q   <= next_ticket_d;
      serve_ticket_q  <= serve_ticket_d;
      arrive_ticket_q <= arrive_ticket_d;
      rr_ptr_q        <= rr_ptr_d;
      disp_q          <= disp_d;
    end
  end

  for (genvar k = 0; k < N_TELLERS; k++) begin : g_lane
    assign load[k] = dispatch && (grant == 3'(k));
    teller_lane #(.SERVICE_TICKS(SERVICE_TICKS)) u_lane (
      .FPGA_clk (FPGA_clk),
      .reset    (reset),
      .tick     (tick_q),
      .load     (load[k]),
      .busy     (busy[k])
    );
  end

  assign pending       = pending_q;
  assign full          = full_q;
  assign arrive_ticket = arrive_ticket_q;
  assign teller_busy   = busy;
  assign disp_valid    = disp_q.valid;
  assign disp_teller   = disp_q.teller;
  assign disp_ticket   = disp_q.ticket;
  assign tick          = tick_q;
endmodule

// File: tb/tb_teller_dispatch_scheduler.sv
// Bench for teller_dispatch_scheduler: two instances (ticket modulo 100 and 4)
// share stimulus and are compared every cycle against a queue-based model.

module tb_teller_dispatch_scheduler;
  localparam int TD = 4, NT = 2, ST = 3, QM = 4;

  logic FPGA_clk, reset, enable, arrive;
  logic [2:0] a_pend, b_pend, a_dt, b_dt;
  logic [6:0] a_at, b_at, a_dk, b_dk;
  logic [1:0] a_busy, b_busy;
  logic a_full, b_full, a_dv, b_dv, a_tick, b_tick;

  teller_dispatch_scheduler #(.TICK_DIV(TD), .N_TELLERS(NT), .SERVICE_TICKS(ST),
    .QMAX(QM), .TICKET_MOD(100)) u_a (
    .FPGA_clk(FPGA_clk), .reset(reset), .enable(enable), .arrive(arrive),
    .pending(a_pend), .full(a_full), .arrive_ticket(a_at), .teller_busy(a_busy),
    .disp_valid(a_dv), .disp_teller(a_dt), .disp_ticket(a_dk), .tick(a_tick));

  teller_dispatch_scheduler #(.TICK_DIV(TD), .N_TELLERS(NT), .SERVICE_TICKS(ST),
    .QMAX(QM), .TICKET_MOD(4)) u_b (
    .FPGA_clk(FPGA_clk), .reset(reset), .enable(enable), .arrive(arrive),
    .pending(b_pend), .full(b_full), .arrive_ticket(b_at), .teller_busy(b_busy),
    .disp_valid(b_dv), .disp_teller(b_dt), .disp_ticket(b_dk), .tick(b_tick));

  initial begin
    FPGA_clk = 1'b0;
    forever #5 FPGA_clk = ~FPGA_clk;
  end

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: waiting customers as a queue of tickets, tellers as remaining ticks
  int mq[2][$];
  int remain[2][NT];
  int rr[2], nxt[2], phase[2], e_at[2], e_dt[2], e_dk[2];
  bit e_dv[2], e_tick[2];

  function automatic int tmod(input int u);
    return (u == 0) ? 100 : 4;
  endfunction

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      int k;
      bit tk, acc;
      if (reset) begin
        mq[u].delete();
        for (int t = 0; t < NT; t++) remain[u][t] = 0;
        rr[u] = 0; nxt[u] = 0; phase[u] = 0;
        e_tick[u] = 0; e_dv[u] = 0; e_dt[u] = 0; e_dk[u] = 0; e_at[u] = 0;
      end else begin
        k   = -1;
        tk  = e_tick[u];
        acc = arrive && (mq[u].size() < QM);
        if (mq[u].size() > 0)
          for (int j = 0; j < NT; j++)
            if (k < 0 && remain[u][(rr[u] + j) % NT] == 0) k = (rr[u] + j) % NT;
        for (int t = 0; t < NT; t++)
          if (tk && remain[u][t] > 0) remain[u][t]--;
        e_dv[u] = (k >= 0);
        if (k >= 0) begin
          remain[u][k] = ST;
          e_dt[u] = k;
          e_dk[u] = mq[u].pop_front();
          rr[u] = (k + 1) % NT;
        end
        if (acc) begin
          mq[u].push_back(nxt[u]);
          e_at[u] = nxt[u];
          nxt[u] = (nxt[u] + 1) % tmod(u);
        end
        e_tick[u] = enable && (phase[u] == TD - 1);
        if (enable) phase[u] = (phase[u] + 1) % TD;
      end
    end
  endtask

  always @(posedge FPGA_clk) begin
    model_step();
    #1;
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        string p;
        int eb;
        p  = (u == 0) ? "a." : "b.";
        eb = 0;
        for (int t = 0; t < NT; t++) if (remain[u][t] > 0) eb |= (1 << t);
        chk({p, "pending"}, int'(u == 0 ? a_pend : b_pend), mq[u].size());
        chk({p, "full"}, int'(u == 0 ? a_full : b_full), int'(mq[u].size() == QM));
        chk({p, "arrive_ticket"}, int'(u == 0 ? a_at : b_at), e_at[u]);
        chk({p, "teller_busy"}, int'(u == 0 ? a_busy : b_busy), eb);
        chk({p, "tick"}, int'(u == 0 ? a_tick : b_tick), int'(e_tick[u]));
        chk({p, "disp_valid"}, int'(u == 0 ? a_dv : b_dv), int'(e_dv[u]));
        if (e_dv[u]) begin
          chk({p, "disp_teller"}, int'(u == 0 ? a_dt : b_dt), e_dt[u]);
          chk({p, "disp_ticket"}, int'(u == 0 ? a_dk : b_dk), e_dk[u]);
        end
      end
    end
  end

  int nt, nb, maxp, nd, na;
  int recd[6], reca[6];
  bit got;

  task automatic wait_disp(input int maxc);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge FPGA_clk);
      got = a_dv;
    end
    if (!got) chk("wait_disp_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; arrive = 1'b0;
    @(negedge FPGA_clk);
    chk_en = 1'b1;
    @(negedge FPGA_clk);

    // Idle ticking
    reset = 1'b0; enable = 1'b1;
    nt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge FPGA_clk);
      if (a_tick) nt++;
    end
    chk("s1_ticks", nt, 4);
    chk("s1_pending", int'(a_pend), 0);
    chk("s1_busy", int'(a_busy), 0);

    // Single customer
    arrive = 1'b1;
    @(negedge FPGA_clk);
    arrive = 1'b0;
    chk("s2_arrive_ticket", int'(a_at), 0);
    chk("s2_no_early_disp", int'(a_dv), 0);
    @(negedge FPGA_clk);
    chk("s2_disp_valid", int'(a_dv), 1);
    chk("s2_disp_teller", int'(a_dt), 0);
    chk("s2_disp_ticket", int'(a_dk), 0);
    chk("s2_busy", int'(a_busy), 1);
    nb = 0;
    for (int i = 0; i < 40 && a_busy != 2'b00; i++) begin
      if (a_tick) nb++;
      @(negedge FPGA_clk);
    end
    chk("s2_busy_cleared", int'(a_busy), 0);
    chk("s2_busy_ticks_3to4", int'(nb >= 3 && nb <= 4), 1);
    chk("s2_pending_end", int'(a_pend), 0);

    // Burst with service frozen, then fill and overflow
    reset = 1'b1; enable = 1'b0;
    @(negedge FPGA_clk);
    reset = 1'b0; arrive = 1'b1;
    maxp = 0; nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge FPGA_clk);
      if (int'(a_pend) > maxp) maxp = a_pend;
      if (a_dv) nd++;
    end
    chk("s3_last_ticket", int'(a_at), 4);
    chk("s3_peak_pending", maxp, 3);
    chk("s3_dispatches", nd, 2);
    @(negedge FPGA_clk);
    chk("s4_pending_full", int'(a_pend), 4);
    chk("s4_full", int'(a_full), 1);
    chk("s4_ticket5", int'(a_at), 5);
    @(negedge FPGA_clk);
    arrive = 1'b0;
    chk("s4_drop_ticket", int'(a_at), 5);
    chk("s4_drop_pending", int'(a_pend), 4);
    chk("s4_drop_full", int'(a_full), 1);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge FPGA_clk);
      if (a_dv) nd++;
    end
    chk("s3_frozen_no_disp", nd, 0);
    enable = 1'b1;
    wait_disp(60);
    chk("s3_rr_teller", int'(a_dt), 0);
    chk("s3_rr_ticket", int'(a_dk), 2);
    arrive = 1'b1;
    @(negedge FPGA_clk);
    arrive = 1'b0;
    chk("s4_next_ticket", int'(a_at), 6);

    // Ticket wrap on the modulo-4 instance
    reset = 1'b1;
    @(negedge FPGA_clk);
    reset = 1'b0; enable = 1'b1; arrive = 1'b1;
    nd = 0; na = 0;
    for (int i = 0; i < 300 && nd < 6; i++) begin
      @(negedge FPGA_clk);
      if (na < 6) begin
        reca[na] = b_at;
        na++;
        if (na == 6) arrive = 1'b0;
      end
      if (b_dv) begin
        recd[nd] = b_dk;
        nd++;
      end
    end
    arrive = 1'b0;
    chk("s5_disp_count", nd, 6);
    for (int i = 0; i < nd; i++) chk("s5_disp_ticket_seq", recd[i], i % 4);
    for (int i = 0; i < na; i++) chk("s5_arrive_ticket_seq", reca[i], i % 4);

    // Reset mid-service
    reset = 1'b1;
    @(negedge FPGA_clk);
    reset = 1'b0; enable = 1'b0; arrive = 1'b1;
    repeat (4) @(negedge FPGA_clk);
    arrive = 1'b0;
    chk("s6_setup_pending", int'(a_pend), 2);
    chk("s6_setup_busy0", int'(a_busy[0]), 1);
    reset = 1'b1;
    @(negedge FPGA_clk);
    chk("s6_rst_pending", int'(a_pend), 0);
    chk("s6_rst_busy", int'(a_busy), 0);
    chk("s6_rst_ticket", int'(a_at), 0);
    chk("s6_rst_disp", int'(a_dv), 0);
    reset = 1'b0;
    @(negedge FPGA_clk);
    chk("s6_post_rst_disp", int'(a_dv), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      arrive = ($urandom_range(0, 99) < 45);
      enable = ($urandom_range(0, 9) < 8);
      reset  = ($urandom_range(0, 299) == 0);
      @(negedge FPGA_clk);
    end
    reset = 1'b0; arrive = 1'b0; enable = 1'b1;
    repeat (3) @(negedge FPGA_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
